// File: rtl/btb_update_ctrl_pkg.sv
// btb_update_ctrl_pkg: shared BTB geometry, entry layout, index hash and FSM encoding
package btb_update_ctrl_pkg;
  localparam int BTB_DEPTH_LOG2 = 5;
  localparam int BTB_TAG_LENGTH = 16;
  localparam int ENTRY_TGT_LSB = 0;
  localparam int ENTRY_TGT_W = 30;
  localparam int ENTRY_TAG_LSB = ENTRY_TGT_LSB + ENTRY_TGT_W;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} btb_state_e;
  function automatic logic [31:0] btb_index(input logic [31:0] pc, input int l);
    return ((pc >> 2) ^ (pc >> (l + 2))) & ((32'd1 << l) - 32'd1);
  endfunction
endpackage

// File: rtl/btb_update_fifo.sv
// btb_update_fifo: 2-push/1-pop fall-through FIFO with tail overwrite and free count
module btb_update_fifo #(
  parameter int W = 8,
  parameter int DL = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push_a,
  input  logic [W-1:0] da,
  input  logic         push_b,
  input  logic [W-1:0] db,
  input  logic         ow,
  input  logic [W-1:0] dow,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [W-1:0] tail,
  output logic         empty,
  output logic [DL:0]  free
);
  localparam int DEPTH = 2 ** DL;
  logic [W-1:0] mem [DEPTH];
  logic [DL:0] wr, rd, cnt, wr_b, wr_t;
  assign cnt = wr - rd;
  assign empty = cnt == '0;
  assign free = (DL+1)'(DEPTH) - cnt;
  assign wr_t = wr - (DL+1)'(1);
  assign wr_b = wr + (DL+1)'(push_a);
  assign tail = mem[wr_t[DL-1:0]];
  // an empty FIFO hands its first push straight to the reader; a sole entry may be overwritten while read
  assign head = empty ? da : (ow && cnt == (DL+1)'(1)) ? dow : mem[rd[DL-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else if (clr) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr_b + (DL+1)'(push_b);
      rd <= rd + (DL+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (ow) mem[wr_t[DL-1:0]] <= dow;
    if (push_a) mem[wr[DL-1:0]] <= da;
    if (push_b) mem[wr_b[DL-1:0]] <= db;
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: BTB write sequencer (clear walk + 2-port update FIFO); BTB_UPDATE_COALESCE_EN merges same-index updates at the tail
module btb_update_ctrl #(
  parameter int BTB_DEPTH_LOG2  = btb_update_ctrl_pkg::BTB_DEPTH_LOG2,
  parameter int BTB_TAG_LENGTH  = btb_update_ctrl_pkg::BTB_TAG_LENGTH,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush_i,
  input  logic                        upd0_valid_i,
  input  logic [31:0]                 upd0_pc_i,
  input  logic [31:0]                 upd0_target_i,
  output logic                        upd0_ready_o,
  input  logic                        upd1_valid_i,
  input  logic [31:0]                 upd1_pc_i,
  input  logic [31:0]                 upd1_target_i,
  output logic                        upd1_ready_o,
  output logic                        btb_we_o,
  output logic [BTB_DEPTH_LOG2-1:0]   btb_windex_o,
  output logic [BTB_TAG_LENGTH+30:0]  btb_wentry_o,
  output logic                        btb_busy_o
);
  import btb_update_ctrl_pkg::*;
  localparam int L = BTB_DEPTH_LOG2;
  localparam int FL = FIFO_DEPTH_LOG2;
  localparam int EW = ENTRY_TAG_LSB + BTB_TAG_LENGTH + 1;
  localparam int DW = L + EW;
  btb_state_e state, state_n;
  logic [L-1:0] clear_cnt;
  logic run, acc0, acc1, pop, fifo_empty, push_a, push_b, ow;
  logic [FL:0] free;
  logic [DW-1:0] u0, u1, da, db, dow, head, tail;
  logic unused_lsbs;
  assign unused_lsbs = ^{upd0_target_i[1:0], upd1_target_i[1:0]};
  // FIFO words carry the hashed index above the BTB entry so coalescing can compare it
  assign u0 = {L'(btb_index(upd0_pc_i, L)), 1'b1, upd0_pc_i[BTB_TAG_LENGTH+1:2], upd0_target_i[31:2]};
  assign u1 = {L'(btb_index(upd1_pc_i, L)), 1'b1, upd1_pc_i[BTB_TAG_LENGTH+1:2], upd1_target_i[31:2]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else state <= state_n;
  end
  always_comb begin
    state_n = flush_i ? CLEAR : (state == CLEAR && &clear_cnt) ? RUN : state;
  end
  always_comb begin
    run = state == RUN && !flush_i;
    upd0_ready_o = run && free != '0;
    upd1_ready_o = run && (free > (FL+1)'(1) || (free == (FL+1)'(1) && !upd0_valid_i));
  end
  assign acc0 = upd0_valid_i && upd0_ready_o;
  assign acc1 = upd1_valid_i && upd1_ready_o;
  assign db = u1;
`ifdef BTB_UPDATE_COALESCE_EN
  logic m0, m1, p0;
  // port 0 is applied before port 1, so port 1 may merge into what port 0 just left at the tail
  assign m0 = acc0 && !fifo_empty && tail[DW-1 -: L] == u0[DW-1 -: L];
  assign p0 = acc0 && !m0;
  assign m1 = acc1 && (acc0 ? u1[DW-1 -: L] == u0[DW-1 -: L] : !fifo_empty && tail[DW-1 -: L] == u1[DW-1 -: L]);
  assign ow = m0 || (m1 && !acc0);
  assign dow = m1 ? u1 : u0;
  assign push_a = p0 || (acc1 && !m1);
  assign da = (p0 && !m1) ? u0 : u1;
  assign push_b = p0 && acc1 && !m1;
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign ow = 1'b0;
  assign dow = '0;
  assign push_a = acc0 || acc1;
  assign da = acc0 ? u0 : u1;
  assign push_b = acc0 && acc1;
`endif
  assign pop = run && (!fifo_empty || push_a);
  btb_update_fifo #(.W(DW), .DL(FL)) u_fifo (
    .clk(clk), .rst_n(rst_n), .clr(flush_i),
    .push_a(push_a), .da(da), .push_b(push_b), .db(db),
    .ow(ow), .dow(dow), .pop(pop),
    .head(head), .tail(tail), .empty(fifo_empty), .free(free)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_cnt <= '0;
      btb_we_o <= 1'b0;
      btb_windex_o <= '0;
      btb_wentry_o <= '0;
      btb_busy_o <= 1'b1;
    end else begin
      clear_cnt <= flush_i ? '0 : state == CLEAR ? clear_cnt + L'(1) : clear_cnt;
      btb_we_o <= !flush_i && (state == CLEAR || pop);
      // stays high through the cycle that shows the final invalidation write
      btb_busy_o <= state == CLEAR || state_n == CLEAR;
      if (!flush_i && state == CLEAR) begin
        btb_windex_o <= clear_cnt;
        btb_wentry_o <= '0;
      end else if (pop) begin
        btb_windex_o <= head[DW-1 -: L];
        btb_wentry_o <= head[EW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: randomized and directed checks of btb_update_ctrl against a queue-based model
module tb_btb_update_ctrl;
  logic clk = 0, rst_n = 0, flush = 0, v0 = 0, v1 = 0;
  logic [31:0] pc0 = 0, pc1 = 0, tg0 = 0, tg1 = 0;
  logic r0, r1, we, busy;
  logic [4:0] widx;
  logic [46:0] went;
  int checks = 0, failures = 0;
  typedef struct {int idx; logic [46:0] entry;} ent_t;
  ent_t q[$];
  bit m_clr, m_we, m_busy;
  int m_pos, m_idx;
  logic [46:0] m_entry;
  always #5 clk = ~clk;
  btb_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .upd0_valid_i(v0), .upd0_pc_i(pc0), .upd0_target_i(tg0), .upd0_ready_o(r0),
    .upd1_valid_i(v1), .upd1_pc_i(pc1), .upd1_target_i(tg1), .upd1_ready_o(r1),
    .btb_we_o(we), .btb_windex_o(widx), .btb_wentry_o(went), .btb_busy_o(busy)
  );
  function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] tgt);
    ent_t e;
    e.idx = int'(((pc >> 2) ^ (pc >> 7)) & 32'd31);
    e.entry = {1'b1, 16'((pc >> 2) & 32'hFFFF), 30'(tgt >> 2)};
    return e;
  endfunction
  function automatic bit exp_r0();
    return !m_clr && !flush && q.size() < 4;
  endfunction
  function automatic bit exp_r1();
    return !m_clr && !flush && (q.size() < 3 || (q.size() == 3 && !v0));
  endfunction
  function automatic void enq(input ent_t u);
`ifdef BTB_UPDATE_COALESCE_EN
    if (q.size() != 0 && q[q.size()-1].idx == u.idx) begin
      q[q.size()-1] = u;
      return;
    end
`endif
    q.push_back(u);
  endfunction
  function automatic void model_reset();
    q.delete();
    m_clr = 1; m_pos = 0; m_we = 0; m_busy = 1; m_idx = 0; m_entry = '0;
  endfunction
  task automatic step();
    bit a0, a1;
    a0 = v0 && exp_r0();
    a1 = v1 && exp_r1();
    if (flush) begin
      q.delete(); m_clr = 1; m_pos = 0; m_we = 0; m_busy = 1;
    end else if (m_clr) begin
      m_we = 1; m_idx = m_pos; m_entry = '0; m_busy = 1; m_pos++;
      if (m_pos == 32) begin m_clr = 0; m_pos = 0; end
    end else begin
      if (a0) enq(mk(pc0, tg0));
      if (a1) enq(mk(pc1, tg1));
      m_busy = 0;
      m_we = q.size() != 0;
      if (m_we) begin
        m_idx = q[0].idx; m_entry = q[0].entry;
        void'(q.pop_front());
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    rst_n = 0; model_reset(); #12;
    checks++;
    if ({we, busy, widx, r0, r1} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0} || went !== '0) begin
      failures++;
      $display("FAIL reset_outputs got we=%0b busy=%0b idx=%0d r=%0b%0b entry=%h exp we=0 busy=1 idx=0 r=00 entry=0", we, busy, widx, r0, r1, went);
    end
    @(posedge clk); #1; rst_n = 1;
  endtask
  task automatic test_clear_walk();
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (r0 !== 1'b0 || r1 !== 1'b0) begin failures++; $display("FAIL clear_ready k=%0d got=%0b%0b exp=00", k, r0, r1); end
      step();
      checks++;
      if ({we, busy, widx} !== {1'b1, 1'b1, 5'(k)} || went !== '0) begin
        failures++; $display("FAIL clear_write k=%0d got we=%0b busy=%0b idx=%0d entry=%h exp we=1 busy=1 idx=%0d entry=0", k, we, busy, widx, went, k);
      end
    end
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b1) begin failures++; $display("FAIL run_ready got=%0b%0b exp=11", r0, r1); end
    step();
    checks++;
    if (busy !== 1'b0 || we !== 1'b0) begin failures++; $display("FAIL run_idle got busy=%0b we=%0b exp busy=0 we=0", busy, we); end
  endtask
  task automatic test_single_update();
    v0 = 1; pc0 = 32'h1C00_0040; tg0 = 32'h1C00_0100; #1;
    checks++;
    if (r0 !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", r0); end
    step(); v0 = 0;
    checks++;
    if (we !== 1'b1 || widx !== 5'h10 || went !== {1'b1, 16'h0010, 30'h0700_0040}) begin
      failures++; $display("FAIL single_write got we=%0b idx=%h entry=%h exp we=1 idx=10 entry=%h", we, widx, went, {1'b1, 16'h0010, 30'h0700_0040});
    end
    step();
    checks++;
    if (we !== 1'b0) begin failures++; $display("FAIL single_pulse got we=%0b exp=0", we); end
  endtask
  task automatic test_dual();
    for (int c = 0; c < 9; c++) begin
      v0 = c < 4; v1 = c < 4;
      pc0 = $urandom & ~32'h3; pc1 = $urandom & ~32'h3; tg0 = $urandom; tg1 = $urandom;
      #1;
      checks++;
      if (r0 !== exp_r0() || r1 !== exp_r1()) begin failures++; $display("FAIL dual_ready c=%0d got=%0b%0b exp=%0b%0b", c, r0, r1, exp_r0(), exp_r1()); end
      if (c == 3) begin
        checks++;
        if (r1 !== 1'b0 || r0 !== 1'b1) begin failures++; $display("FAIL dual_free1 got=%0b%0b exp=10", r0, r1); end
      end
      step();
      checks++;
      if (we !== m_we || (m_we && (widx !== 5'(m_idx) || went !== m_entry))) begin
        failures++; $display("FAIL dual_write c=%0d got we=%0b idx=%0d entry=%h exp we=%0b idx=%0d entry=%h", c, we, widx, went, m_we, m_idx, m_entry);
      end
    end
  endtask
  task automatic test_flush();
    for (int c = 0; c < 3; c++) begin
      v0 = 1; v1 = 1; pc0 = $urandom & ~32'h3; pc1 = $urandom & ~32'h3; tg0 = $urandom; tg1 = $urandom;
      step();
    end
    flush = 1; #1;
    checks++;
    if (r0 !== 1'b0 || r1 !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b%0b exp=00", r0, r1); end
    step(); flush = 0; v0 = 0; v1 = 0;
    checks++;
    if (we !== 1'b0) begin failures++; $display("FAIL flush_nowrite got we=%0b exp=0", we); end
    for (int k = 0; k < 7; k++) begin
      step();
      checks++;
      if ({we, widx} !== {1'b1, 5'(k)} || went !== '0) begin failures++; $display("FAIL flush_walk k=%0d got we=%0b idx=%0d entry=%h exp we=1 idx=%0d entry=0", k, we, widx, went, k); end
    end
    flush = 1; step(); flush = 0;
    checks++;
    if (we !== 1'b0) begin failures++; $display("FAIL reflush_nowrite got we=%0b exp=0", we); end
    for (int k = 0; k < 32; k++) begin
      step();
      checks++;
      if ({we, busy, widx} !== {1'b1, 1'b1, 5'(k)} || went !== '0) begin failures++; $display("FAIL reflush_walk k=%0d got we=%0b idx=%0d exp we=1 idx=%0d", k, we, widx, k); end
    end
  endtask
  task automatic test_async_reset();
    v0 = 1; v1 = 1; pc0 = 32'h0000_0044; pc1 = 32'h0000_0088; tg0 = $urandom; tg1 = $urandom;
    step(); step(); v0 = 0; v1 = 0;
    #2; rst_n = 0; #1;
    checks++;
    if ({we, busy, widx, r0, r1} !== {1'b0, 1'b1, 5'd0, 1'b0, 1'b0} || went !== '0) begin
      failures++; $display("FAIL async_reset got we=%0b busy=%0b idx=%0d r=%0b%0b entry=%h exp we=0 busy=1 idx=0 r=00 entry=0", we, busy, widx, r0, r1, went);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    for (int k = 0; k < 32; k++) begin
      step();
      checks++;
      if ({we, busy, widx} !== {1'b1, 1'b1, 5'(k)} || went !== '0) begin failures++; $display("FAIL async_walk k=%0d got we=%0b idx=%0d exp we=1 idx=%0d", k, we, widx, k); end
    end
    step();
    checks++;
    if (busy !== 1'b0 || r0 !== 1'b1) begin failures++; $display("FAIL async_run got busy=%0b r0=%0b exp busy=0 r0=1", busy, r0); end
  endtask
  task automatic test_same_index();
    int nx, exp_nx;
    logic [46:0] last;
    logic [31:0] tx2;
    nx = 0; last = '0; tx2 = 32'hABCD_1234;
`ifdef BTB_UPDATE_COALESCE_EN
    exp_nx = 1;
`else
    exp_nx = 2;
`endif
    for (int c = 0; c < 8; c++) begin
      v0 = c < 3; v1 = c < 2;
      pc0 = c == 0 ? 32'h4 : c == 1 ? 32'h10 : 32'h100;
      pc1 = c == 0 ? 32'hC : 32'h100;
      tg0 = c == 2 ? tx2 : 32'h1111_0000; tg1 = 32'h2222_0000;
      step();
      checks++;
      if (we !== m_we || (m_we && (widx !== 5'(m_idx) || went !== m_entry))) begin
        failures++; $display("FAIL same_idx_write c=%0d got we=%0b idx=%0d entry=%h exp we=%0b idx=%0d entry=%h", c, we, widx, went, m_we, m_idx, m_entry);
      end
      if (we && widx == 5'd2) begin nx++; last = went; end
    end
    checks++;
    if (nx != exp_nx || last !== {1'b1, 16'h0040, 30'(tx2 >> 2)}) begin
      failures++; $display("FAIL same_idx_count got writes=%0d entry=%h exp writes=%0d entry=%h", nx, last, exp_nx, {1'b1, 16'h0040, 30'(tx2 >> 2)});
    end
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      v0 = $urandom_range(0, 3) != 0; v1 = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      pc0 = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 7)) << 2);
      pc1 = ($urandom & 32'hFFFC_0000) | (32'($urandom_range(0, 7)) << 2);
      tg0 = $urandom; tg1 = $urandom;
      #1;
      checks++;
      if (r0 !== exp_r0() || r1 !== exp_r1()) begin failures++; $display("FAIL rand_ready c=%0d got=%0b%0b exp=%0b%0b", c, r0, r1, exp_r0(), exp_r1()); end
      step();
      checks++;
      if (we !== m_we || busy !== m_busy || (m_we && (widx !== 5'(m_idx) || went !== m_entry))) begin
        failures++; $display("FAIL rand_out c=%0d got we=%0b busy=%0b idx=%0d entry=%h exp we=%0b busy=%0b idx=%0d entry=%h", c, we, busy, widx, went, m_we, m_busy, m_idx, m_entry);
      end
    end
    flush = 0; v0 = 0; v1 = 0;
  endtask
  initial begin
    test_reset();
    test_clear_walk();
    test_single_update();
    test_dual();
    test_flush();
    test_async_reset();
    test_same_index();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
